// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch bridge: FSM state encoding,
// the CPU request-size code for a word fetch and the wait-counter width.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        ACK  = 2'd3
    } ifetch_state_t;

    // isiz value the CPU uses to request a 32-bit instruction word
    localparam logic [1:0] ISIZ_WORD = 2'b10;

    // Wait-state counter width; holds 0..15 extra cycles per halfword
    localparam int CTR_W = 4;

    // True when the CPU is presenting a word fetch
    function automatic logic isWordReq(input logic [1:0] isiz);
        return isiz == ISIZ_WORD;
    endfunction

endpackage

// File: rtl/ifetch_wait_ctr.sv
// Loadable down-counter that times each external halfword access.
// It stops at zero and raises zero_o so the controller knows the
// memory data has settled and may be sampled on the next rising edge.
module ifetch_wait_ctr
    import ifetch_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CTR_W-1:0] loadVal_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CTR_W-1:0] count_q;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ifetch_bridge.sv
// Instruction-fetch bridge: turns one 32-bit CPU fetch into two 16-bit reads
// of an asynchronous external memory, assembles the word little-endian and
// returns it with a one-cycle acknowledge.
// Optional feature: define IFETCH_LASTWORD_EN to add a one-entry last-word
// buffer so a repeated fetch of the same word is answered without touching
// the external memory.
module ifetch_bridge
    import ifetch_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned MADR_W      = 24
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [63:0]       iadr_i,
    input  logic [1:0]        isiz_i,
    output logic              iack_o,
    output logic [31:0]       idat_o,
    output logic [MADR_W-1:0] madr_o,
    output logic              moe_o,
    input  logic [15:0]       mdat_i
);

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(WAIT_STATES);

    ifetch_state_t     state_q, state_d;
    logic [MADR_W-1:0] madr_q, madr_d;
    logic [31:0]       idat_q, idat_d;
    logic              ctrLoad;
    logic              ctrDec;
    logic              ctrZero;
    logic              reqHit;
    logic [31:0]       hitData;

    // Address bits outside the external space and the byte offset within
    // the word do not select anything; misaligned fetches get the whole word
    logic unusedIadr;
    assign unusedIadr = ^{iadr_i[63:MADR_W], iadr_i[1:0]};

    ifetch_wait_ctr u_waitCtr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (ctrLoad),
        .loadVal_i (WAIT_LOAD),
        .dec_i     (ctrDec),
        .zero_o    (ctrZero)
    );

`ifdef IFETCH_LASTWORD_EN
    logic              bufValid_q;
    logic [MADR_W-3:0] bufTag_q;
    logic [31:0]       bufData_q;
    logic              bufFill;

    assign reqHit  = bufValid_q && (bufTag_q == iadr_i[MADR_W-1:2]);
    assign hitData = bufData_q;
    // Only a fetch that completes both reads refills; aborted ones never do
    assign bufFill = (state_q == HI) && (state_d == ACK);

    // Remember the most recently assembled word and which word address it came from
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bufValid_q <= 1'b0;
            bufTag_q   <= '0;
            bufData_q  <= '0;
        end else if (bufFill) begin
            bufValid_q <= 1'b1;
            bufTag_q   <= madr_q[MADR_W-1:2];
            bufData_q  <= idat_d;
        end
    end
`else
    assign reqHit  = 1'b0;
    assign hitData = '0;
`endif

    // State, external address and assembled word registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            madr_q  <= '0;
            idat_q  <= '0;
        end else begin
            state_q <= state_d;
            madr_q  <= madr_d;
            idat_q  <= idat_d;
        end
    end

    // Next-state logic: walk the low then high halfword, sampling each when
    // the wait counter has run out, and abort if the CPU withdraws its request
    always_comb begin
        state_d = state_q;
        madr_d  = madr_q;
        idat_d  = idat_q;
        ctrLoad = 1'b0;
        ctrDec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (isWordReq(isiz_i)) begin
                    if (reqHit) begin
                        state_d = ACK;
                        idat_d  = hitData;
                    end else begin
                        state_d = LO;
                        madr_d  = {iadr_i[MADR_W-1:2], 2'b00};
                        ctrLoad = 1'b1;
                    end
                end
            end
            LO: begin
                if (!isWordReq(isiz_i)) begin
                    state_d = IDLE;
                end else if (ctrZero) begin
                    idat_d[15:0] = mdat_i;
                    madr_d[1]    = 1'b1;
                    ctrLoad      = 1'b1;
                    state_d      = HI;
                end else begin
                    ctrDec = 1'b1;
                end
            end
            HI: begin
                if (!isWordReq(isiz_i)) begin
                    state_d = IDLE;
                end else if (ctrZero) begin
                    idat_d[31:16] = mdat_i;
                    state_d       = ACK;
                end else begin
                    ctrDec = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign iack_o = (state_q == ACK);
    assign moe_o  = (state_q == LO) || (state_q == HI);
    assign madr_o = madr_q;
    assign idat_o = idat_q;

endmodule

// File: tb/tb_ifetch_bridge.sv
// Self-checking bench for ifetch_bridge. Two instances share the clock and
// reset: dut0 runs with one wait state, dut1 with none. Each test task drives
// CPU requests, pushes the word it expects into a scoreboard queue and pops
// it when the acknowledge appears, checking data, latency and the external
// address/output-enable sequence. Last-word buffer behaviour is expected when
// IFETCH_LASTWORD_EN is defined.
module tb_ifetch_bridge;

    localparam int W0 = 1;
    localparam int W1 = 0;

    logic        clk;
    logic        reset;
    logic [63:0] iadr0, iadr1;
    logic [1:0]  isiz0, isiz1;
    logic        iack0, iack1;
    logic [31:0] idat0, idat1;
    logic [23:0] madr0, madr1;
    logic        moe0, moe1;
    logic [15:0] mdat0, mdat1;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] expQ[$];
    logic [23:0] trMadr [0:63];
    logic        trMoe  [0:63];

    // External memory model: a few fixed locations, a pattern everywhere else
    function automatic logic [15:0] memData(input logic [23:0] addr);
        case (addr)
            24'hFFFF00: return 16'h0013;
            24'hFFFF02: return 16'h0000;
            24'h000124: return 16'h0113;
            24'h000126: return 16'h1241;
            default:    return addr[15:0] ^ {addr[23:16], 8'h3C};
        endcase
    endfunction

    function automatic logic [31:0] expWord(input logic [23:0] addr);
        logic [23:0] base;
        base = {addr[23:2], 2'b00};
        return {memData(base | 24'h2), memData(base)};
    endfunction

    assign mdat0 = memData(madr0);
    assign mdat1 = memData(madr1);

    ifetch_bridge #(.WAIT_STATES(W0), .MADR_W(24)) dut0 (
        .clk_i   (clk),
        .reset_i (reset),
        .iadr_i  (iadr0),
        .isiz_i  (isiz0),
        .iack_o  (iack0),
        .idat_o  (idat0),
        .madr_o  (madr0),
        .moe_o   (moe0),
        .mdat_i  (mdat0)
    );

    ifetch_bridge #(.WAIT_STATES(W1), .MADR_W(24)) dut1 (
        .clk_i   (clk),
        .reset_i (reset),
        .iadr_i  (iadr1),
        .isiz_i  (isiz1),
        .iack_o  (iack1),
        .idat_o  (idat1),
        .madr_o  (madr1),
        .moe_o   (moe1),
        .mdat_i  (mdat1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called in cycle 1 (just after the edge that starts it); traces madr/moe
    // per cycle and returns the cycle number in which iack was seen
    task automatic waitAck(input int sel, input int budget, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            trMadr[c] = (sel != 0) ? madr1 : madr0;
            trMoe[c]  = (sel != 0) ? moe1 : moe0;
            if (((sel != 0) ? iack1 : iack0) === 1'b1) begin
                seen = 1'b1;
                cyc  = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [63:0] addr);
        @(posedge clk);
        #1;
        if (sel != 0) begin
            iadr1 = addr;
            isiz1 = 2'b10;
        end else begin
            iadr0 = addr;
            isiz0 = 2'b10;
        end
    endtask

    task automatic releaseReq(input int sel);
        @(posedge clk);
        #1;
        if (sel != 0) isiz1 = 2'b00;
        else          isiz0 = 2'b00;
    endtask

    task automatic test_reset();
        iadr0 = '0;
        iadr1 = '0;
        isiz0 = 2'b00;
        isiz1 = 2'b00;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        nChecks++;
        if ({iack0, moe0, madr0, idat0} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_dut0: got iack=%b moe=%b madr=%h idat=%h, expected all zero", iack0, moe0, madr0, idat0);
        end
        nChecks++;
        if ({iack1, moe1, madr1, idat1} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_dut1: got iack=%b moe=%b madr=%h idat=%h, expected all zero", iack1, moe1, madr1, idat1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_fetch();
        int cyc;
        bit seen;
        logic [31:0] exp;
        applyStimulus(0, 64'hFFFF_FFFF_FFFF_FF00);
        expQ.push_back(32'h0000_0013);
        waitAck(0, 20, cyc, seen);
        exp = expQ.pop_front();
        nChecks++;
        if (cyc !== 2 * W0 + 4) begin
            nFails++;
            $display("[TB] FAIL basic_latency: got cycle %0d (seen=%b), expected %0d", cyc, seen, 2 * W0 + 4);
        end
        nChecks++;
        if (idat0 !== exp) begin
            nFails++;
            $display("[TB] FAIL basic_data: got %h expected %h", idat0, exp);
        end
        nChecks++;
        if ({trMadr[2], trMadr[3], trMadr[4], trMadr[5]} !== {24'hFFFF00, 24'hFFFF00, 24'hFFFF02, 24'hFFFF02}) begin
            nFails++;
            $display("[TB] FAIL basic_madr: got %h %h %h %h expected FFFF00 FFFF00 FFFF02 FFFF02", trMadr[2], trMadr[3], trMadr[4], trMadr[5]);
        end
        nChecks++;
        if ({trMoe[1], trMoe[2], trMoe[3], trMoe[4], trMoe[5], trMoe[6]} !== 6'b011110) begin
            nFails++;
            $display("[TB] FAIL basic_moe: got %b%b%b%b%b%b expected 011110", trMoe[1], trMoe[2], trMoe[3], trMoe[4], trMoe[5], trMoe[6]);
        end
        releaseReq(0);
        @(negedge clk);
        nChecks++;
        if (iack0 !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL basic_single_ack: iack got %b expected 0", iack0);
        end
    endtask

    task automatic test_lastword();
        int cyc;
        bit seen;
        logic [31:0] exp;
        int hitLat;
        logic hitMoe;
`ifdef IFETCH_LASTWORD_EN
        hitLat = 2;
        hitMoe = 1'b0;
`else
        hitLat = 2 * W0 + 4;
        hitMoe = 1'b1;
`endif
        applyStimulus(0, 64'h124);
        expQ.push_back(32'h1241_0113);
        waitAck(0, 20, cyc, seen);
        exp = expQ.pop_front();
        nChecks++;
        if ({cyc, idat0} !== {2 * W0 + 4, exp}) begin
            nFails++;
            $display("[TB] FAIL lastword_first: got cycle %0d data %h expected cycle %0d data %h", cyc, idat0, 2 * W0 + 4, exp);
        end
        releaseReq(0);

        applyStimulus(0, 64'h124);
        expQ.push_back(32'h1241_0113);
        waitAck(0, 20, cyc, seen);
        exp = expQ.pop_front();
        nChecks++;
        if ({cyc, idat0} !== {hitLat, exp}) begin
            nFails++;
            $display("[TB] FAIL lastword_repeat: got cycle %0d data %h expected cycle %0d data %h", cyc, idat0, hitLat, exp);
        end
        nChecks++;
        if (trMoe[2] !== hitMoe) begin
            nFails++;
            $display("[TB] FAIL lastword_repeat_moe: cycle 2 moe got %b expected %b", trMoe[2], hitMoe);
        end
        releaseReq(0);

        applyStimulus(0, 64'h128);
        expQ.push_back(expWord(24'h128));
        waitAck(0, 20, cyc, seen);
        exp = expQ.pop_front();
        nChecks++;
        if ({cyc, idat0, trMadr[2]} !== {2 * W0 + 4, exp, 24'h000128}) begin
            nFails++;
            $display("[TB] FAIL lastword_miss: got cycle %0d data %h madr %h expected cycle %0d data %h madr 000128", cyc, idat0, trMadr[2], 2 * W0 + 4, exp);
        end
        releaseReq(0);
    endtask

    task automatic test_misaligned();
        int cyc;
        bit seen;
        logic [31:0] exp;
        applyStimulus(0, 64'h126);
        expQ.push_back(32'h1241_0113);
        waitAck(0, 20, cyc, seen);
        exp = expQ.pop_front();
        nChecks++;
        if ({cyc, idat0} !== {2 * W0 + 4, exp}) begin
            nFails++;
            $display("[TB] FAIL misaligned_data: got cycle %0d data %h expected cycle %0d data %h", cyc, idat0, 2 * W0 + 4, exp);
        end
        nChecks++;
        if ({trMadr[2], trMadr[3], trMadr[4], trMadr[5]} !== {24'h000124, 24'h000124, 24'h000126, 24'h000126}) begin
            nFails++;
            $display("[TB] FAIL misaligned_madr: got %h %h %h %h expected 000124 000124 000126 000126", trMadr[2], trMadr[3], trMadr[4], trMadr[5]);
        end
        releaseReq(0);
    endtask

    task automatic test_zero_wait();
        int cyc;
        bit seen;
        logic [31:0] exp;
        applyStimulus(1, 64'h124);
        expQ.push_back(32'h1241_0113);
        waitAck(1, 20, cyc, seen);
        exp = expQ.pop_front();
        nChecks++;
        if (cyc !== 2 * W1 + 4) begin
            nFails++;
            $display("[TB] FAIL zero_wait_latency: got cycle %0d (seen=%b) expected %0d", cyc, seen, 2 * W1 + 4);
        end
        nChecks++;
        if (idat1 !== exp) begin
            nFails++;
            $display("[TB] FAIL zero_wait_data: got %h expected %h", idat1, exp);
        end
        nChecks++;
        if ({trMadr[2], trMadr[3], trMoe[2], trMoe[3]} !== {24'h000124, 24'h000126, 1'b1, 1'b1}) begin
            nFails++;
            $display("[TB] FAIL zero_wait_bus: got madr %h %h moe %b%b expected 000124 000126 moe 11", trMadr[2], trMadr[3], trMoe[2], trMoe[3]);
        end
        releaseReq(1);
    endtask

    task automatic test_withdraw();
        int acks;
        logic moeC2, moeC3;
        applyStimulus(0, 64'h300);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        moeC2 = moe0;
        @(posedge clk);
        #1;
        isiz0 = 2'b00;
        @(negedge clk);
        moeC3 = moe0;
        @(posedge clk);
        #1;
        @(negedge clk);
        nChecks++;
        if ({moeC2, moeC3, moe0} !== 3'b110) begin
            nFails++;
            $display("[TB] FAIL withdraw_moe: cycles 2..4 got %b%b%b expected 110", moeC2, moeC3, moe0);
        end
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (iack0 === 1'b1) acks++;
            @(negedge clk);
        end
        nChecks++;
        if (acks !== 0) begin
            nFails++;
            $display("[TB] FAIL withdraw_no_ack: got %0d acknowledges expected 0", acks);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        logic [31:0] exp;
        logic [63:0] a;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, 8'h00, 24'h400000 + 24'(i * 16) + 24'($urandom_range(0, 3))};
            iadr0 = a;
            isiz0 = 2'b10;
            expQ.push_back(expWord(a[23:0]));
            waitAck(0, 20, cyc, seen);
            exp = expQ.pop_front();
            nChecks++;
            if ({cyc, idat0, madr0} !== {2 * W0 + 4, exp, a[23:2], 2'b10}) begin
                nFails++;
                $display("[TB] FAIL back_to_back_%0d: got cycle %0d data %h madr %h expected cycle %0d data %h madr %h", i, cyc, idat0, madr0, 2 * W0 + 4, exp, {a[23:2], 2'b10});
            end
            @(posedge clk);
            #1;
        end
        isiz0 = 2'b00;
        @(negedge clk);
        nChecks++;
        if ({iack0, moe0} !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL back_to_back_idle: got iack=%b moe=%b expected 0 0", iack0, moe0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int acks;
        applyStimulus(0, 64'h500);
        @(negedge clk);
        @(posedge clk);
        #1;
        nChecks++;
        if (moe0 !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reset_mid_pre: moe in cycle 2 got %b expected 1", moe0);
        end
        #2 reset = 1'b1;
        #1;
        nChecks++;
        if ({moe0, iack0, madr0, idat0} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset_mid_async: got moe=%b iack=%b madr=%h idat=%h expected all zero", moe0, iack0, madr0, idat0);
        end
        isiz0 = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (iack0 === 1'b1) acks++;
        end
        nChecks++;
        if (acks !== 0) begin
            nFails++;
            $display("[TB] FAIL reset_mid_no_ack: got %0d acknowledges expected 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_lastword();
        test_misaligned();
        test_zero_wait();
        test_withdraw();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Hard stop in case a wait somewhere never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no completion expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ifetch_bridge.md
# ifetch_bridge

Instruction-fetch bridge between the Polaris CPU's I-master port and a 16-bit external program memory (asynchronous SRAM/flash) with fixed access time. It accepts a 32-bit instruction-word request, performs two halfword reads with a programmable number of wait states, assembles the word little-endian, and returns it with a single-cycle acknowledge. It sits directly downstream of the CPU's `iadr_o`/`isiz_o`/`iack_i`/`idat_i` port.

## Interface
- `WAIT_STATES`, default 1: extra cycles per halfword access (0..15).
- `MADR_W`, default 24: external byte-address width.

- `clk_i`  in  1  system clock, all state on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `iadr_i`  in  64  CPU fetch address.
- `isiz_i`  in  2  request size; `2'b10` = word request, any other value = idle.
- `iack_o`  out  1  one-cycle acknowledge; `idat_o` valid in the same cycle.
- `idat_o`  out  32  fetched instruction word, registered.
- `madr_o`  out  MADR_W  external halfword address, bit 0 always 0.
- `moe_o`  out  1  external output enable, active-high.
- `mdat_i`  in  16  external read data.

## Operation
- States: IDLE, LO, HI, ACK.
- IDLE: `moe_o`=0. When `isiz_i`=10, latch `{iadr_i[MADR_W-1:2],2'b00}` into `madr_o`, load wait counter with WAIT_STATES, go LO. `iadr_i[1:0]` ignored (misaligned requests fetch the containing word); bits above MADR_W ignored.
- LO: `moe_o`=1. Counter decrements each cycle; in the cycle it reads 0, capture `mdat_i` into `idat_o[15:0]`, set `madr_o[1]`=1, reload counter, go HI.
- HI: same; on count 0 capture `mdat_i` into `idat_o[31:16]`, go ACK.
- ACK: `moe_o`=0, `iack_o`=1 for exactly one cycle; next state IDLE unconditionally.
- Withdrawal: if `isiz_i`≠10 in any LO/HI cycle, abort at that edge: next state IDLE, no `iack_o`, `idat_o` holds partial content (undefined to CPU).
- `idat_o` holds its last value until next capture.
- Reset (any state): state IDLE; `iack_o`=0, `idat_o`=0, `madr_o`=0, `moe_o`=0, counter 0 — all asserted asynchronously, aborting any fetch in flight with no acknowledge.

## Timing
- Cycle 1 = first cycle `isiz_i`=10 is visible in IDLE.
- LO occupies cycles 2..W+2, HI cycles W+3..2W+3, `iack_o` high in cycle 2W+4 (W=1 → cycle 6; W=0 → cycle 4).
- `madr_o` stable for W+1 cycles per halfword; `mdat_i` sampled on the rising edge ending the last cycle of each phase.
- CPU must hold `iadr_i`/`isiz_i` until it sees `iack_o`; it drops `isiz_i` in the cycle after. The forced ACK→IDLE step guarantees a stale request is never re-sampled. Minimum acknowledge-to-acknowledge spacing: 2W+4 cycles.

## Configuration
- `IFETCH_LASTWORD_EN` defined: a one-entry buffer holds valid bit, tag `iadr_i[MADR_W-1:2]`, and the last assembled word. A request in IDLE that hits goes directly to ACK (iack in cycle 2, `moe_o` never asserted). A miss proceeds normally and refills the buffer on entering ACK. An aborted fetch does not update it. Reset clears valid.
- Undefined: no buffer, every request performs both external reads.

## Structure
- Shared package `ifetch_pkg`: state enum (IDLE, LO, HI, ACK), `ISIZ_WORD` = 2'b10, counter width constant (4 bits).
- One sub-module: `ifetch_wait_ctr` (loadable down-counter with zero flag, async reset).

## Test plan
- Reset asserted mid-LO (W=1) → `moe_o`, `iack_o`, `madr_o` go 0 without waiting for a clock edge; no `iack_o` after release.
- Request `iadr_i`=64'hFFFF_FFFF_FFFF_FF00, memory 0xFFFF00=16'h0013, 0xFFFF02=16'h0000 → `madr_o`=FFFF00 in cycles 2–3, FFFF02 in cycles 4–5, `iack_o` cycle 6 only, `idat_o`=32'h0000_0013.
- WAIT_STATES=0, `iadr_i`=0x124, data 16'h0113/16'h1241 → `iack_o` in cycle 4, `idat_o`=32'h1241_0113.
- `iadr_i`=0x126 → `madr_o`=0x124 then 0x126; word from 0x124 returned.
- Drop `isiz_i` in cycle 3 → state IDLE at that edge, `moe_o`=0 from cycle 4, `iack_o` never asserted.
- With `IFETCH_LASTWORD_EN`: fetch 0x124, then repeat 0x124 → second `iack_o` in cycle 2, `moe_o` stays 0; then 0x128 → full external fetch (cycle 6).
